dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between two requesters: the pipelined core's data port and a host port used for program/data preload and debug inspection.
- Arbitrates one RAM access per cycle with core priority, bounded by a host starvation limit.
- Drives the RAM's daddr/MemWrite/MemRead/ddata_w and routes the 1-cycle-latency ddata_r back to the owner of the read.
- Sits between main's data interface and ram in the top level.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/arb_starve_ctr.sv | 39 +++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter: read-return owner tag
// and the starvation counter width.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_HOST
  } owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating host-starvation counter with synchronous clear; sat_o flags that
// the pending host request must win the next contention.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  input  logic zero_i,
  output logic sat_o
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || zero_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// Core-priority arbiter for the single-port data RAM with a host starvation bound.
// One access per cycle; reads return 2 cycles after grant; a losing core sees c_stall.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_SIZE    = 10,
  parameter int DATA_SIZE    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CLEAR,
  input  logic                 c_req,
  input  logic                 c_we,
  input  logic [ADDR_SIZE-1:0] c_addr,
  input  logic [DATA_SIZE-1:0] c_wdata,
  output logic                 c_stall,
  output logic [DATA_SIZE-1:0] c_rdata,
  output logic                 c_rvalid,
  input  logic                 h_req,
  input  logic                 h_we,
  input  logic [ADDR_SIZE-1:0] h_addr,
  input  logic [DATA_SIZE-1:0] h_wdata,
  output logic                 h_gnt,
  output logic [DATA_SIZE-1:0] h_rdata,
  output logic                 h_rvalid,
  output logic [ADDR_SIZE-1:0] daddr,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic [DATA_SIZE-1:0] ddata_w,
  input  logic [DATA_SIZE-1:0] ddata_r
);

  logic   host_win, core_win, starve_sat;
  owner_t rd_owner_q, rd_owner_d;
  logic   c_rvalid_q, h_rvalid_q;
  logic [DATA_SIZE-1:0] c_rdata_q, h_rdata_q;

  assign host_win = h_req & (~c_req | starve_sat);
  assign core_win = c_req & ~host_win;
  assign c_stall  = c_req & ~core_win;
  assign h_gnt    = host_win;

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .clear_i(CLEAR),
    .inc_i  (h_req & ~host_win),
    .zero_i (host_win | ~h_req),
    .sat_o  (starve_sat)
  );

  always_comb begin
    daddr    = '0;
    ddata_w  = '0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    if (core_win) begin
      daddr    = c_addr;
      ddata_w  = c_wdata;
      MemWrite = c_we;
      MemRead  = ~c_we;
    end else if (host_win) begin
      daddr    = h_addr;
      ddata_w  = h_wdata;
      MemWrite = h_we;
      MemRead  = ~h_we;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (core_win && !c_we) begin
      rd_owner_d = OWN_CORE;
    end else if (host_win && !h_we) begin
      rd_owner_d = OWN_HOST;
    end
  end

  // CLEAR drops any read in flight exactly as the async reset does.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_owner_q <= OWN_NONE;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      h_rdata_q  <= '0;
    end else if (CLEAR) begin
      rd_owner_q <= OWN_NONE;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      h_rdata_q  <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      c_rvalid_q <= (rd_owner_q == OWN_CORE);
      h_rvalid_q <= (rd_owner_q == OWN_HOST);
      if (rd_owner_q == OWN_CORE) c_rdata_q <= ddata_r;
      if (rd_owner_q == OWN_HOST) h_rdata_q <= ddata_r;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign h_rvalid = h_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign h_rdata  = h_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, directed scenarios plus random traffic,
// reference grant/read model feeding per-requester scoreboards.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        CLK;
  logic        RESET_N, CLEAR;
  logic        c_req, c_we, c_stall, c_rvalid;
  logic [9:0]  c_addr;
  logic [31:0] c_wdata, c_rdata;
  logic        h_req, h_we, h_gnt, h_rvalid;
  logic [9:0]  h_addr;
  logic [31:0] h_wdata, h_rdata;
  logic [9:0]  daddr;
  logic        MemWrite, MemRead;
  logic [31:0] ddata_w, ddata_r;

  dmem_arbiter #(
    .ADDR_SIZE(10), .DATA_SIZE(32), .STARVE_LIMIT(LIM)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_stall(c_stall), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .daddr(daddr), .MemWrite(MemWrite), .MemRead(MemRead),
    .ddata_w(ddata_w), .ddata_r(ddata_r)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [9:0] a);
    return 32'(a) * 32'h11;
  endfunction

  // Single-port synchronous RAM with 1-cycle read latency.
  logic [31:0] ram [0:1023];
  bit          ram_seen [0:1023];
  always @(posedge CLK) begin
    if (MemWrite) begin
      ram[daddr]      <= ddata_w;
      ram_seen[daddr] <= 1'b1;
    end
    if (MemRead) ddata_r <= ram_seen[daddr] ? ram[daddr] : init_val(daddr);
  end

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } rd_t;

  rd_t         cq[$], hq[$];
  logic [31:0] sh_mem [0:1023];
  bit          sh_seen [0:1023];
  int          losses = 0;
  int          clr_cyc = -10;
  logic [31:0] last_c = '0, last_h = '0;
  bit          last_cw, last_hw, dut_hgnt, dut_cstall;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sh_rd(input logic [9:0] a);
    return sh_seen[a] ? sh_mem[a] : init_val(a);
  endfunction

  // One cycle: model grant, check the RAM-side drive, log expected reads.
  task automatic step();
    bit          hw, cw, we;
    logic [9:0]  a;
    logic [31:0] wd;
    @(negedge CLK);
    hw = h_req && (!c_req || losses == LIM);
    cw = c_req && !hw;
    dut_hgnt   = h_gnt;
    dut_cstall = c_stall;
    a  = cw ? c_addr : (hw ? h_addr : 10'd0);
    wd = cw ? c_wdata : (hw ? h_wdata : 32'd0);
    we = cw ? c_we : (hw ? h_we : 1'b0);
    chk("h_gnt", 32'(h_gnt), 32'(hw));
    chk("c_stall", 32'(c_stall), 32'(c_req && !cw));
    chk("daddr", 32'(daddr), 32'(a));
    chk("ddata_w", ddata_w, wd);
    chk("MemWrite", 32'(MemWrite), 32'((cw || hw) && we));
    chk("MemRead", 32'(MemRead), 32'((cw || hw) && !we));
    if (cw || hw) begin
      if (we) begin
        sh_mem[a]  = wd;
        sh_seen[a] = 1'b1;
      end else if (cw) begin
        cq.push_back('{cyc, sh_rd(a)});
      end else begin
        hq.push_back('{cyc, sh_rd(a)});
      end
    end
    if (CLEAR) begin
      losses  = 0;
      clr_cyc = cyc;
      while (cq.size() > 0 && cq[cq.size()-1].cyc >= cyc - 1) void'(cq.pop_back());
      while (hq.size() > 0 && hq[hq.size()-1].cyc >= cyc - 1) void'(hq.pop_back());
    end else if (h_req && !hw) begin
      losses = (losses < LIM) ? losses + 1 : LIM;
    end else begin
      losses = 0;
    end
    last_cw = cw;
    last_hw = hw;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input bit cr, input bit cwe, input logic [9:0] ca, input logic [31:0] cd,
                        input bit hr, input bit hwe, input logic [9:0] ha, input logic [31:0] hd);
    c_req = cr; c_we = cwe; c_addr = ca; c_wdata = cd;
    h_req = hr; h_we = hwe; h_addr = ha; h_wdata = hd;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    CLEAR   = 1'b0;
    set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    cq.delete();
    hq.delete();
    losses = 0;
    last_c = '0;
    last_h = '0;
    @(negedge CLK);
    chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("rst_h_rvalid", 32'(h_rvalid), 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_h_rdata", h_rdata, 32'd0);
    chk("rst_daddr", 32'(daddr), 32'd0);
    chk("rst_ddata_w", ddata_w, 32'd0);
    chk("rst_MemWrite", 32'(MemWrite), 32'd0);
    chk("rst_MemRead", 32'(MemRead), 32'd0);
    chk("rst_h_gnt", 32'(h_gnt), 32'd0);
    chk("rst_c_stall", 32'(c_stall), 32'd0);
    @(negedge CLK);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
  endtask

  // Read-return monitor: each logged read must surface exactly 2 cycles after grant.
  initial begin
    forever begin
      @(negedge CLK);
      if (cyc == clr_cyc + 1) begin
        last_c = '0;
        last_h = '0;
      end
      if (cq.size() > 0 && cq[0].cyc + 2 == cyc) begin
        chk("c_rvalid", 32'(c_rvalid), 32'd1);
        chk("c_rdata", c_rdata, cq[0].dat);
        last_c = cq[0].dat;
        void'(cq.pop_front());
      end else begin
        chk("c_rvalid_idle", 32'(c_rvalid), 32'd0);
        chk("c_rdata_hold", c_rdata, last_c);
      end
      if (hq.size() > 0 && hq[0].cyc + 2 == cyc) begin
        chk("h_rvalid", 32'(h_rvalid), 32'd1);
        chk("h_rdata", h_rdata, hq[0].dat);
        last_h = hq[0].dat;
        void'(hq.pop_front());
      end else begin
        chk("h_rvalid_idle", 32'(h_rvalid), 32'd0);
        chk("h_rdata_hold", h_rdata, last_h);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit c_pend, h_pend;
    int ca;
    RESET_N = 1'b0;
    CLEAR   = 1'b0;
    set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    do_reset();

    // Host write then read back.
    set_in(0, 0, 10'd0, 32'd0, 1, 1, 10'h010, 32'hDEADBEEF);
    step();
    set_in(0, 0, 10'd0, 32'd0, 1, 0, 10'h010, 32'd0);
    step();
    set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    repeat (3) step();

    // Core priority, then host takes the free cycle.
    set_in(1, 0, 10'd3, 32'd0, 1, 0, 10'd4, 32'd0);
    step();
    chk("prio_hgnt", 32'(dut_hgnt), 32'd0);
    chk("prio_cstall", 32'(dut_cstall), 32'd0);
    set_in(0, 0, 10'd0, 32'd0, 1, 0, 10'd4, 32'd0);
    step();
    chk("prio_host_next", 32'(dut_hgnt), 32'd1);
    set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    repeat (3) step();

    // Continuous contention: host forced in every 5th cycle.
    ca = 20;
    for (int k = 0; k < 10; k++) begin
      set_in(1, 0, 10'(ca), 32'd0, 1, 0, 10'd5, 32'd0);
      step();
      chk("starve_pattern", 32'(dut_hgnt), 32'(k % 5 == 4));
      chk("starve_cstall", 32'(dut_cstall), 32'(k % 5 == 4));
      if (last_cw) ca++;
    end
    set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    repeat (3) step();

    // Back-to-back reads by different owners.
    set_in(1, 0, 10'd1, 32'd0, 0, 0, 10'd0, 32'd0);
    step();
    set_in(0, 0, 10'd0, 32'd0, 1, 0, 10'd2, 32'd0);
    step();
    set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    repeat (3) step();

    // Reset while a core read is in flight, then a normal read.
    set_in(1, 0, 10'd1, 32'd0, 0, 0, 10'd0, 32'd0);
    step();
    do_reset();
    set_in(1, 0, 10'd1, 32'd0, 0, 0, 10'd0, 32'd0);
    step();
    set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    repeat (3) step();

    // CLEAR after 3 host losses: the next contention still goes to the core.
    ca = 40;
    for (int k = 0; k < 4; k++) begin
      CLEAR = (k == 3);
      set_in(1, 0, 10'(ca), 32'd0, 1, 0, 10'd6, 32'd0);
      step();
      if (last_cw) ca++;
    end
    CLEAR = 1'b0;
    set_in(1, 0, 10'(ca), 32'd0, 1, 0, 10'd6, 32'd0);
    step();
    chk("clear_no_force", 32'(dut_hgnt), 32'd0);
    set_in(0, 0, 10'd0, 32'd0, 1, 0, 10'd6, 32'd0);
    step();
    set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    repeat (3) step();

    // Random traffic; each requester holds its request until granted.
    c_pend = 0;
    h_pend = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!c_pend && $urandom_range(0, 2) == 0) begin
        c_pend  = 1;
        c_we    = 1'($urandom_range(0, 1));
        c_addr  = 10'($urandom_range(0, 15));
        c_wdata = $urandom;
      end
      if (!h_pend && $urandom_range(0, 3) == 0) begin
        h_pend  = 1;
        h_we    = 1'($urandom_range(0, 1));
        h_addr  = 10'($urandom_range(0, 15));
        h_wdata = $urandom;
      end
      c_req = c_pend;
      h_req = h_pend;
      CLEAR = ($urandom_range(0, 149) == 0);
      step();
      if (last_cw) c_pend = 0;
      if (last_hw) h_pend = 0;
    end
    CLEAR = 1'b0;
    set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
    repeat (4) step();
    chk("cq_drained", 32'(cq.size()), 32'd0);
    chk("hq_drained", 32'(hq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
